// File: rtl/dkong_rom_loader.sv
// Routes the HPS download stream into the Donkey Kong ROM write ports, mod and DIP
// registers, and holds the game core in reset until a full ROM image has loaded.
module dkong_rom_loader #(
  parameter logic [31:0] MAIN_SIZE  = 32'h8000,
  parameter logic [31:0] SND_BASE   = 32'hE000,
  parameter logic [31:0] WAV_BASE   = 32'h10000,
  parameter logic [31:0] MIN_BYTES  = 32'h10000,
  parameter int unsigned REL_CYCLES = 16
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic        I_DL_DOWNLOAD,
  input  logic        I_DL_WR,
  input  logic [7:0]  I_DL_INDEX,
  input  logic [24:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_DATA,
  output logic [15:0] O_ROM_ADDR,
  output logic [7:0]  O_ROM_DATA,
  output logic        O_MAIN_WE,
  output logic        O_SND_WE,
  output logic        O_WAV_WE,
  output logic [7:0]  O_MOD,
  output logic [7:0]  O_DIP_SW,
  output logic        O_CORE_RESETn,
  output logic        O_BUSY,
  output logic        O_LOAD_ERR
);

  localparam logic [31:0] SND_END  = SND_BASE + 32'd4096;
  localparam logic [31:0] WAV_END  = WAV_BASE + 32'd65536;
  localparam logic [15:0] REL_LOAD = 16'(REL_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic        dl_q;
  logic [24:0] cnt_q, cnt_d;
  logic [15:0] rel_q, rel_d;
  logic        err_q, err_d;
  logic        main_we_q, main_we_d;
  logic        snd_we_q, snd_we_d;
  logic        wav_we_q, wav_we_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [7:0]  mod_q, mod_d;
  logic [7:0]  dip_q, dip_d;

  logic        dl_rise, dl_fall, rom_strobe;
  logic        in_main, in_snd, in_wav;
  logic [31:0] addr32;

  always_comb begin
    dl_rise    = I_DL_DOWNLOAD & ~dl_q;
    dl_fall    = ~I_DL_DOWNLOAD & dl_q;
    rom_strobe = I_DL_WR & I_DL_DOWNLOAD & (I_DL_INDEX == 8'd0) & (state_q == S_LOAD);
    addr32     = {7'd0, I_DL_ADDR};
    in_main    = addr32 < MAIN_SIZE;
    in_snd     = (addr32 >= SND_BASE) && (addr32 < SND_END);
    in_wav     = (addr32 >= WAV_BASE) && (addr32 < WAV_END);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (dl_rise) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (rom_strobe && (cnt_q != '1)) cnt_d = cnt_q + 25'd1;
        if (dl_fall) state_d = S_CHECK;
      end
      S_CHECK: begin
        if ({7'd0, cnt_q} >= MIN_BYTES) begin
          state_d = S_RELEASE;
          err_d   = 1'b0;
          rel_d   = REL_LOAD;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_RELEASE: begin
        if (dl_rise) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          // Leave when the counter reaches zero, so RELEASE lasts REL_CYCLES cycles.
          if (rel_q != '0) rel_d = rel_q - 16'd1;
          if (rel_q <= 16'd1) state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    main_we_d  = rom_strobe & in_main;
    snd_we_d   = rom_strobe & ~in_main & in_snd;
    wav_we_d   = rom_strobe & ~in_main & ~in_snd & in_wav;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    if (main_we_d) begin
      rom_addr_d = I_DL_ADDR[15:0];
      rom_data_d = I_DL_DATA;
    end else if (snd_we_d) begin
      rom_addr_d = 16'(addr32 - SND_BASE);
      rom_data_d = I_DL_DATA;
    end else if (wav_we_d) begin
      rom_addr_d = 16'(addr32 - WAV_BASE);
      rom_data_d = I_DL_DATA;
    end
    mod_d = mod_q;
    dip_d = dip_q;
    if (I_DL_WR && (I_DL_INDEX == 8'd1)) mod_d = I_DL_DATA;
    if (I_DL_WR && (I_DL_INDEX == 8'd254) && (I_DL_ADDR == '0)) dip_d = I_DL_DATA;
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b0;
      cnt_q      <= '0;
      rel_q      <= '0;
      err_q      <= 1'b0;
      main_we_q  <= 1'b0;
      snd_we_q   <= 1'b0;
      wav_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      mod_q      <= '0;
      dip_q      <= '0;
    end else begin
      state_q    <= state_d;
      dl_q       <= I_DL_DOWNLOAD;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
      main_we_q  <= main_we_d;
      snd_we_q   <= snd_we_d;
      wav_we_q   <= wav_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      mod_q      <= mod_d;
      dip_q      <= dip_d;
    end
  end

  assign O_ROM_ADDR    = rom_addr_q;
  assign O_ROM_DATA    = rom_data_q;
  assign O_MAIN_WE     = main_we_q;
  assign O_SND_WE      = snd_we_q;
  assign O_WAV_WE      = wav_we_q;
  assign O_MOD         = mod_q;
  assign O_DIP_SW      = dip_q;
  assign O_CORE_RESETn = (state_q == S_RUN);
  assign O_BUSY        = (state_q != S_RUN);
  assign O_LOAD_ERR    = err_q;

endmodule

// File: tb/tb_dkong_rom_loader.sv
// Randomized directed bench for dkong_rom_loader against a byte-level reference model.
module tb_dkong_rom_loader;

  localparam logic [31:0] MIN = 32'h1000;
  localparam int unsigned REL = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl, wr;
  logic [7:0]  idx;
  logic [24:0] addr;
  logic [7:0]  data;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        main_we, snd_we, wav_we;
  logic [7:0]  mod_o, dip_o;
  logic        core_rstn, busy, load_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       in_load = 1'b0;
  int       bytes_m = 0;
  logic [7:0] mod_m = '0, dip_m = '0;
  int       exp_main = 0, exp_snd = 0, exp_wav = 0;
  int       obs_main = 0, obs_snd = 0, obs_wav = 0;

  dkong_rom_loader #(.MIN_BYTES(MIN), .REL_CYCLES(REL)) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_DL_DOWNLOAD(dl),
    .I_DL_WR      (wr),
    .I_DL_INDEX   (idx),
    .I_DL_ADDR    (addr),
    .I_DL_DATA    (data),
    .O_ROM_ADDR   (rom_addr),
    .O_ROM_DATA   (rom_data),
    .O_MAIN_WE    (main_we),
    .O_SND_WE     (snd_we),
    .O_WAV_WE     (wav_we),
    .O_MOD        (mod_o),
    .O_DIP_SW     (dip_o),
    .O_CORE_RESETn(core_rstn),
    .O_BUSY       (busy),
    .O_LOAD_ERR   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe per call: driven on a negedge, result sampled on the next negedge.
  task automatic strobe(input logic [7:0] i, input logic [24:0] a, input logic [7:0] d);
    int unsigned ai;
    logic [2:0]  ewe;
    logic [15:0] eaddr;
    ai    = a;
    ewe   = 3'b000;
    eaddr = '0;
    if (i == 8'd0 && in_load && dl) begin
      bytes_m++;
      if (ai < 32'h8000) begin ewe = 3'b100; eaddr = 16'(ai); exp_main++; end
      else if (ai >= 32'hE000 && ai < 32'hF000) begin ewe = 3'b010; eaddr = 16'(ai - 32'hE000); exp_snd++; end
      else if (ai >= 32'h10000 && ai < 32'h20000) begin ewe = 3'b001; eaddr = 16'(ai - 32'h10000); exp_wav++; end
    end
    if (i == 8'd1) mod_m = d;
    if (i == 8'd254 && a == '0) dip_m = d;
    wr = 1'b1; idx = i; addr = a; data = d;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    obs_main += int'(main_we);
    obs_snd  += int'(snd_we);
    obs_wav  += int'(wav_we);
    chk("we", {main_we, snd_we, wav_we}, ewe);
    if (ewe != 3'b000) begin
      chk("rom_addr", rom_addr, eaddr);
      chk("rom_data", rom_data, d);
    end
    if (i != 8'd0) begin
      chk("mod", mod_o, mod_m);
      chk("dip", dip_o, dip_m);
    end
  endtask

  task automatic start_dl();
    dl = 1'b1;
    @(negedge clk);
    in_load = 1'b1;
    bytes_m = 0;
    chk("load_rstn", core_rstn, 1'b0);
    chk("load_busy", busy, 1'b1);
    chk("load_err_clr", load_err, 1'b0);
  endtask

  task automatic end_dl();
    int n;
    dl = 1'b0;
    in_load = 1'b0;
    if (bytes_m >= int'(MIN)) begin
      n = 0;
      while (n <= 40 && core_rstn !== 1'b1) begin
        @(negedge clk);
        n++;
        if (core_rstn !== 1'b1) chk("rel_busy", busy, 1'b1);
      end
      chk("rel_latency", n, 2 + REL);
      chk("run_busy", busy, 1'b0);
      chk("run_err", load_err, 1'b0);
    end else begin
      repeat (4) @(negedge clk);
      chk("short_err", load_err, 1'b1);
      chk("short_rstn", core_rstn, 1'b0);
      chk("short_busy", busy, 1'b1);
    end
  endtask

  task automatic rand_load(input int nrom);
    int k;
    k = 0;
    while (k < nrom) begin
      if ($urandom_range(0, 31) == 0) begin
        if ($urandom_range(0, 1) == 0) strobe(8'd1, 25'($urandom_range(0, 3)), 8'($urandom));
        else strobe(8'd254, 25'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        strobe(8'd0, 25'($urandom_range(0, 32'h27FFF)), 8'($urandom));
        k++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; dl = 1'b0; wr = 1'b0; idx = '0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", {main_we, snd_we, wav_we}, 3'b000);
    chk("rst_addr", rom_addr, 16'h0);
    chk("rst_data", rom_data, 8'h0);
    chk("rst_mod", mod_o, 8'h0);
    chk("rst_dip", dip_o, 8'h0);
    chk("rst_rstn", core_rstn, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_err", load_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sequential image 0..0xFFFF
    start_dl();
    for (int a = 0; a < 32'h10000; a++) strobe(8'd0, 25'(a), 8'($urandom));
    chk("main_pulses", obs_main, exp_main);
    chk("snd_pulses", obs_snd, exp_snd);
    chk("wav_pulses", obs_wav, exp_wav);
    chk("main_total", obs_main, 32'h8000);
    chk("snd_total", obs_snd, 32'h1000);
    end_dl();

    // Strobes outside LOAD
    strobe(8'd0, 25'h10, 8'h5A);
    strobe(8'd1, 25'h0, 8'h04);
    strobe(8'd254, 25'h0, 8'h80);
    strobe(8'd254, 25'h3, 8'h33);
    chk("run_hold", core_rstn, 1'b1);

    // Short image from RUN, with a wave-window byte
    start_dl();
    strobe(8'd0, 25'h10005, 8'hA5);
    @(negedge clk);
    chk("wav_pulse_end", {main_we, snd_we, wav_we}, 3'b000);
    rand_load(int'(MIN) - 2);
    end_dl();

    // Exactly MIN index-0 bytes, interleaved non-ROM strobes must not count
    start_dl();
    rand_load(int'(MIN));
    end_dl();

    // Valid image, then abort during release, then reset mid-load
    start_dl();
    rand_load(int'(MIN));
    dl = 1'b0; in_load = 1'b0;
    repeat (5) @(negedge clk);
    chk("releasing_rstn", core_rstn, 1'b0);
    start_dl();
    strobe(8'd0, 25'h100, 8'h11);
    strobe(8'd1, 25'h0, 8'h02);
    wr = 1'b1; idx = 8'd0; addr = 25'h0200; data = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    mod_m = '0; dip_m = '0; in_load = 1'b0;
    chk("arst_we", {main_we, snd_we, wav_we}, 3'b000);
    chk("arst_addr", rom_addr, 16'h0);
    chk("arst_data", rom_data, 8'h0);
    chk("arst_mod", mod_o, 8'h0);
    chk("arst_dip", dip_o, 8'h0);
    chk("arst_rstn", core_rstn, 1'b0);
    chk("arst_busy", busy, 1'b1);
    chk("arst_err", load_err, 1'b0);
    dl = 1'b0;
    wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) strobe(8'd0, 25'(k * 32'h3001), 8'($urandom));
    chk("post_rst_rstn", core_rstn, 1'b0);
    chk("post_rst_busy", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
